// File: rtl/msi_snoop_bus_controller.sv
// -----------------------------------------------------------------------------
// msi_snoop_bus_controller
//   Shared snooping bus for a two-core MSI system. Owns the 512x32 backing
//   memory, arbitrates coherence requests round-robin, broadcasts the granted
//   request to the other core and returns data from either the snooping
//   cache (abort) or memory.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   req_valid[1:0]           per-core request pending
//   req_type0/1, req_addr0/1 request type (00 INV, 01 WMISS, 10 RMISS, 11 none)
//                            and address {tag[3:0], index[4:0]}
//   wb_valid, wb_addr0/1, wb_data0/1   per-core write-back
//   snoop_abort, snoop_data0/1         snooper holds the block and supplies it
//   grant                    one-hot bus owner (SNOOP..RESP)
//   snoop_valid/type/addr    broadcast of the granted request
//   resp_valid/data/from_cache         response to the requester
//   wb_ack                   one-cycle write-back acknowledge
//   busy                     controller not idle
// -----------------------------------------------------------------------------
module msi_snoop_bus_controller #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_type0,
    input  logic [1:0]  req_type1,
    input  logic [8:0]  req_addr0,
    input  logic [8:0]  req_addr1,
    input  logic [1:0]  wb_valid,
    input  logic [8:0]  wb_addr0,
    input  logic [8:0]  wb_addr1,
    input  logic [31:0] wb_data0,
    input  logic [31:0] wb_data1,
    input  logic [1:0]  snoop_abort,
    input  logic [31:0] snoop_data0,
    input  logic [31:0] snoop_data1,
    output logic [1:0]  grant,
    output logic [1:0]  snoop_valid,
    output logic [1:0]  snoop_type,
    output logic [8:0]  snoop_addr,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_from_cache,
    output logic [1:0]  wb_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SNOOP, MEM_READ, RESP} state_t;

    localparam logic [1:0] BUS_INVALIDATE = 2'b00;
    localparam logic [1:0] BUS_NONE       = 2'b11;
    localparam logic [3:0] LAT_LAST       = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic        ptr;        // round-robin preference: 0 -> core0 wins ties
    logic        win;        // index of the core owning the bus
    logic [1:0]  lat_type;
    logic [8:0]  lat_addr;
    logic [3:0]  cnt;

    // Backing store: powers up zero, deliberately outside the reset domain.
    logic [31:0] mem [512] = '{default: 32'h0};

    logic [1:0]  req_ok;
    logic [1:0]  wb_pend;
    logic        pick;
    logic        sn_abort;
    logic [31:0] sn_data;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;

    // A write-back whose ack is on the bus this cycle is already done; the
    // core only drops wb_valid at the end of the ack cycle, so mask it here.
    assign wb_pend  = wb_valid & ~wb_ack;
    assign req_ok   = {req_valid[1] && (req_type1 != BUS_NONE),
                       req_valid[0] && (req_type0 != BUS_NONE)};
    assign pick     = (req_ok == 2'b11) ? ptr : req_ok[1];
    // Snoop response comes from the core that does not own the bus.
    assign sn_abort = win ? snoop_abort[0] : snoop_abort[1];
    assign sn_data  = win ? snoop_data0 : snoop_data1;

    // Memory write port: write-backs in IDLE, cache-to-cache refresh in SNOOP.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_addr0;
        mem_wdata = wb_data0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (wb_pend[0]) begin
                        mem_we = 1'b1;
                    end else if (wb_pend[1]) begin
                        mem_we    = 1'b1;
                        mem_waddr = wb_addr1;
                        mem_wdata = wb_data1;
                    end
                end
                SNOOP: begin
                    if (lat_type != BUS_INVALIDATE && sn_abort) begin
                        mem_we    = 1'b1;
                        mem_waddr = lat_addr;
                        mem_wdata = sn_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= 1'b0;
            win             <= 1'b0;
            lat_type        <= 2'b00;
            lat_addr        <= 9'h0;
            cnt             <= 4'h0;
            grant           <= 2'b00;
            snoop_valid     <= 2'b00;
            snoop_type      <= 2'b00;
            snoop_addr      <= 9'h0;
            resp_valid      <= 2'b00;
            resp_data       <= 32'h0;
            resp_from_cache <= 1'b0;
            wb_ack          <= 2'b00;
            busy            <= 1'b0;
        end else begin
            wb_ack <= 2'b00;
            case (state)
                IDLE: begin
                    if (wb_pend != 2'b00) begin
                        wb_ack <= wb_pend[0] ? 2'b01 : 2'b10;
                    end else if (req_ok != 2'b00) begin
                        win         <= pick;
                        lat_type    <= pick ? req_type1 : req_type0;
                        lat_addr    <= pick ? req_addr1 : req_addr0;
                        grant       <= pick ? 2'b10 : 2'b01;
                        snoop_valid <= pick ? 2'b01 : 2'b10;
                        snoop_type  <= pick ? req_type1 : req_type0;
                        snoop_addr  <= pick ? req_addr1 : req_addr0;
                        busy        <= 1'b1;
                        state       <= SNOOP;
                    end
                end
                SNOOP: begin
                    snoop_valid <= 2'b00;
                    if (lat_type == BUS_INVALIDATE) begin
                        resp_data       <= 32'h0;
                        resp_from_cache <= 1'b0;
                        resp_valid      <= win ? 2'b10 : 2'b01;
                        state           <= RESP;
                    end else if (sn_abort) begin
                        resp_data       <= sn_data;
                        resp_from_cache <= 1'b1;
                        resp_valid      <= win ? 2'b10 : 2'b01;
                        state           <= RESP;
                    end else begin
                        cnt   <= 4'h0;
                        state <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (cnt == LAT_LAST) begin
                        resp_data       <= mem[lat_addr];
                        resp_from_cache <= 1'b0;
                        resp_valid      <= win ? 2'b10 : 2'b01;
                        cnt             <= 4'h0;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 2'b00;
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    ptr        <= ~win;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
